// File: rtl/nibble_add_sched_if.sv
// Bundle of the requester, shared-column and result signals for nibble_add_sched.
// The slave modport is the scheduler's view; the master modport is the view of
// the surrounding logic (requesters, adder column and result consumer).
// ADD_SCHED_OVERFLOW_EN adds the res_v overflow flag to the result group.
interface nibble_add_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_A;
    logic [WIDTH-1:0] req0_B;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_A;
    logic [WIDTH-1:0] req1_B;
    logic             req1_cin;

    logic [3:0]       col_A;
    logic [3:0]       col_B;
    logic             col_cin;
    logic [3:0]       col_s;
    logic             col_cout;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;
`ifdef ADD_SCHED_OVERFLOW_EN
    logic             res_v;

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_cin,
        output req0_ready,
        input  req1_valid, req1_A, req1_B, req1_cin,
        output req1_ready,
        output col_A, col_B, col_cin,
        input  col_s, col_cout,
        output res_valid, res_sum, res_cout, res_id, res_v,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_A, req0_B, req0_cin,
        input  req0_ready,
        output req1_valid, req1_A, req1_B, req1_cin,
        input  req1_ready,
        input  col_A, col_B, col_cin,
        output col_s, col_cout,
        input  res_valid, res_sum, res_cout, res_id, res_v,
        output res_ready
    );
`else
    modport slave (
        input  req0_valid, req0_A, req0_B, req0_cin,
        output req0_ready,
        input  req1_valid, req1_A, req1_B, req1_cin,
        output req1_ready,
        output col_A, col_B, col_cin,
        input  col_s, col_cout,
        output res_valid, res_sum, res_cout, res_id,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_A, req0_B, req0_cin,
        input  req0_ready,
        output req1_valid, req1_A, req1_B, req1_cin,
        input  req1_ready,
        input  col_A, col_B, col_cin,
        output col_s, col_cout,
        input  res_valid, res_sum, res_cout, res_id,
        output res_ready
    );
`endif
endinterface

// File: rtl/nibble_add_sched.sv
// Nibble-serial add scheduler: shares one external 4-bit adder column between
// two requesters, LS nibble first, carry chained through carry_reg.
// WIDTH must be a multiple of 4 and at least 8.
// Optional feature macro: ADD_SCHED_OVERFLOW_EN (adds res_v, signed overflow).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; ready goes to the granted requester
//   RUN   | one nibble per cycle through the shared column
//   DONE  | result held on res_* until res_ready
module nibble_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    nibble_add_sched_if.slave bus
);
    localparam int NNIB  = WIDTH / 4;
    localparam int NIB_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NNIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [NIB_W-1:0] nib;
    logic             owner;
    logic             last_grant;

    logic             grant;
    logic             grant_ok;
    logic [NIB_W+1:0] nib_base;

    assign nib_base = {nib, 2'b00};

    // Round-robin arbitration: a tie goes to whoever was not served last.
    always_comb begin
        grant    = 1'b0;
        grant_ok = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated with reset so nothing looks accepted while held in reset.
    assign bus.req0_ready = Reset_n && (state == IDLE) && grant_ok && !grant;
    assign bus.req1_ready = Reset_n && (state == IDLE) && grant_ok && grant;

    // Drive the current operand nibbles and chained carry to the shared column.
    always_comb begin
        bus.col_A   = 4'h0;
        bus.col_B   = 4'h0;
        bus.col_cin = 1'b0;
        if (state == RUN) begin
            bus.col_A   = a_reg[nib_base +: 4];
            bus.col_B   = b_reg[nib_base +: 4];
            bus.col_cin = carry_reg;
        end
    end

    // Scheduler FSM with operand, partial-sum and carry registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            nib        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        a_reg      <= grant ? bus.req1_A   : bus.req0_A;
                        b_reg      <= grant ? bus.req1_B   : bus.req0_B;
                        carry_reg  <= grant ? bus.req1_cin : bus.req0_cin;
                        nib        <= '0;
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[nib_base +: 4] <= bus.col_s;
                    carry_reg              <= bus.col_cout;
                    if (nib == NIB_LAST) begin
                        state <= DONE;
                    end else begin
                        nib <= nib + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = (state == DONE);
    assign bus.res_sum   = sum_reg;
    assign bus.res_cout  = carry_reg;
    assign bus.res_id    = owner;

`ifdef ADD_SCHED_OVERFLOW_EN
    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign bus.res_v = (state == DONE) && (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                       && (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);
`endif
endmodule

// File: tb/tb_nibble_add_sched.sv
// Scoreboard bench for nibble_add_sched: requests push the arithmetic result
// into a queue, a negedge monitor checks grants, latency and held results.
module tb_nibble_add_sched;
    localparam int WIDTH = 16;
    localparam int NNIB  = WIDTH / 4;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             v;
        int               hs;
    } exp_t;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    logic             rv [2];
    logic [WIDTH-1:0] ra [2];
    logic [WIDTH-1:0] rb [2];
    logic             rc [2];
    logic             res_rdy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   hs_count [2] = '{0, 0};
    exp_t sb [$];
    int   id_log [$];

    logic             busy_m      = 1'b0;
    logic             lg_m        = 1'b1;
    logic             res_hold    = 1'b0;
    logic             expect_drop = 1'b0;
    logic             late_seen   = 1'b0;
    logic [WIDTH-1:0] hold_sum;
    logic             hold_cout;
    logic             hold_id;
    logic             m_g;
    logic [WIDTH:0]   m_full;
    exp_t             m_e;

    logic [4:0] col_full;

    nibble_add_sched_if #(.WIDTH(WIDTH)) bus ();

    nibble_add_sched #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    assign bus.req0_valid = rv[0];
    assign bus.req0_A     = ra[0];
    assign bus.req0_B     = rb[0];
    assign bus.req0_cin   = rc[0];
    assign bus.req1_valid = rv[1];
    assign bus.req1_A     = ra[1];
    assign bus.req1_B     = rb[1];
    assign bus.req1_cin   = rc[1];
    assign bus.res_ready  = res_rdy;

    // Ideal 4-bit adder column.
    assign col_full     = {1'b0, bus.col_A} + {1'b0, bus.col_B} + {4'b0, bus.col_cin};
    assign bus.col_s    = col_full[3:0];
    assign bus.col_cout = col_full[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    // Monitor: grant model, handshake capture and result scoreboard.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            sb.delete();
            busy_m      = 1'b0;
            lg_m        = 1'b1;
            res_hold    = 1'b0;
            expect_drop = 1'b0;
            late_seen   = 1'b0;
        end else begin
            if (expect_drop) begin
                chk("res_valid_after_accept", bus.res_valid, 0);
                expect_drop = 1'b0;
            end
            if (busy_m) begin
                chk("ready0_busy", bus.req0_ready, 0);
                chk("ready1_busy", bus.req1_ready, 0);
            end else if (rv[0] || rv[1]) begin
                m_g = (rv[0] && rv[1]) ? ~lg_m : rv[1];
                chk("ready0_grant", bus.req0_ready, (m_g == 1'b0));
                chk("ready1_grant", bus.req1_ready, (m_g == 1'b1));
                m_full   = {1'b0, ra[m_g]} + {1'b0, rb[m_g]} + {{WIDTH{1'b0}}, rc[m_g]};
                m_e.id   = int'(m_g);
                m_e.sum  = m_full[WIDTH-1:0];
                m_e.cout = m_full[WIDTH];
                m_e.v    = (ra[m_g][WIDTH-1] == rb[m_g][WIDTH-1]) &&
                           (m_full[WIDTH-1] != ra[m_g][WIDTH-1]);
                m_e.hs   = cyc + 1;
                sb.push_back(m_e);
                hs_count[m_g] = hs_count[m_g] + 1;
                lg_m   = m_g;
                busy_m = 1'b1;
            end

            if (bus.res_valid) begin
                if (!res_hold) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        m_e = sb[0];
                        chk("res_sum", bus.res_sum, m_e.sum);
                        chk("res_cout", bus.res_cout, m_e.cout);
                        chk("res_id", bus.res_id, m_e.id);
                        chk("latency", cyc, m_e.hs + NNIB);
`ifdef ADD_SCHED_OVERFLOW_EN
                        chk("res_v", bus.res_v, m_e.v);
`endif
                        id_log.push_back(int'(bus.res_id));
                    end
                    hold_sum  = bus.res_sum;
                    hold_cout = bus.res_cout;
                    hold_id   = bus.res_id;
                    res_hold  = 1'b1;
                end else begin
                    chk("hold_sum", bus.res_sum, hold_sum);
                    chk("hold_cout", bus.res_cout, hold_cout);
                    chk("hold_id", bus.res_id, hold_id);
                end
                if (res_rdy) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    res_hold    = 1'b0;
                    busy_m      = 1'b0;
                    expect_drop = 1'b1;
                    late_seen   = 1'b0;
                end
            end else begin
`ifdef ADD_SCHED_OVERFLOW_EN
                chk("res_v_not_done", bus.res_v, 0);
`endif
                if (busy_m && !late_seen && sb.size() > 0 && cyc > sb[0].hs + NNIB) begin
                    fail_now("result_late");
                    late_seen = 1'b1;
                end
            end
        end
    end

    task automatic wait_hs(input int id, input int start);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge Clk);
            #1;
            if (hs_count[id] != start) got = 1;
        end
        if (!got) fail_now("handshake_timeout");
    endtask

    task automatic send(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin);
        int start;
        start  = hs_count[id];
        ra[id] = a;
        rb[id] = b;
        rc[id] = cin;
        rv[id] = 1'b1;
        wait_hs(id, start);
        rv[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge Clk);
            #1;
            if (!busy_m && sb.size() == 0) got = 1;
        end
        if (!got) fail_now("drain_timeout");
    endtask

    task automatic both_pair(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1);
        int  s0, s1;
        bit  d0 = 0, d1 = 0;
        s0 = hs_count[0];
        s1 = hs_count[1];
        ra[0] = a0; rb[0] = a0; rc[0] = 1'b0; rv[0] = 1'b1;
        ra[1] = a1; rb[1] = a1; rc[1] = 1'b0; rv[1] = 1'b1;
        for (int i = 0; i < 200 && !(d0 && d1); i++) begin
            @(posedge Clk);
            #1;
            if (hs_count[0] != s0) begin d0 = 1; rv[0] = 1'b0; end
            if (hs_count[1] != s1) begin d1 = 1; rv[1] = 1'b0; end
        end
        if (!(d0 && d1)) fail_now("pair_timeout");
        rv[0] = 1'b0;
        rv[1] = 1'b0;
    endtask

    initial begin
        int  s[2];
        int  s1;
        bit  got;
        rv[0] = 1'b0; rv[1] = 1'b0;
        ra[0] = '0;   ra[1] = '0;
        rb[0] = '0;   rb[1] = '0;
        rc[0] = 1'b0; rc[1] = 1'b0;
        res_rdy = 1'b1;

        // Reset values
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_sum", bus.res_sum, 0);
        chk("rst_res_cout", bus.res_cout, 0);
        chk("rst_res_id", bus.res_id, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_col_A", bus.col_A, 0);
        chk("rst_col_B", bus.col_B, 0);
        chk("rst_col_cin", bus.col_cin, 0);
`ifdef ADD_SCHED_OVERFLOW_EN
        chk("rst_res_v", bus.res_v, 0);
`endif
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Nibble carry propagation and full-width wrap
        send(0, 16'h00FF, 16'h0001, 1'b0);
        wait_idle();
        send(1, 16'hFFFF, 16'h0001, 1'b0);
        wait_idle();
        send(0, 16'h1234, 16'h0000, 1'b1);
        wait_idle();

        // Arbitration: both valid straight out of reset
        Reset_n = 1'b0;
        ra[0] = 16'h0001; rb[0] = 16'h0001; rc[0] = 1'b0; rv[0] = 1'b1;
        ra[1] = 16'h0002; rb[1] = 16'h0002; rc[1] = 1'b0; rv[1] = 1'b1;
        #2;
        chk("rst_ready0_valid", bus.req0_ready, 0);
        chk("rst_ready1_valid", bus.req1_ready, 0);
        @(posedge Clk);
        #1;
        id_log.delete();
        Reset_n = 1'b1;
        both_pair(16'h0001, 16'h0002);
        wait_idle();
        both_pair(16'h0001, 16'h0002);
        wait_idle();
        if (id_log.size() < 3) begin
            fail_now("arb_result_count");
        end else begin
            chk("arb_first_id", id_log[0], 0);
            chk("arb_second_id", id_log[1], 1);
            chk("arb_third_id", id_log[2], 0);
        end

        // Backpressure in DONE with requester 1 waiting
        res_rdy = 1'b0;
        send(0, 16'h0ABC, 16'h0F0F, 1'b1);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge Clk);
            #1;
            if (bus.res_valid) got = 1;
        end
        if (!got) fail_now("bp_valid_timeout");
        s1 = hs_count[1];
        ra[1] = 16'h8001; rb[1] = 16'h8001; rc[1] = 1'b0; rv[1] = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        res_rdy = 1'b1;
        wait_hs(1, s1);
        rv[1] = 1'b0;
        wait_idle();

        // Reset in the middle of RUN
        send(0, 16'h3333, 16'hDDDD, 1'b1);
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        chk("nib2_col_A", bus.col_A, 4'h3);
        chk("nib2_col_B", bus.col_B, 4'hD);
        chk("nib2_col_cin", bus.col_cin, 1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_col_A", bus.col_A, 0);
        chk("abort_col_B", bus.col_B, 0);
        chk("abort_col_cin", bus.col_cin, 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        send(0, 16'h0003, 16'h0004, 1'b0);
        wait_idle();

`ifdef ADD_SCHED_OVERFLOW_EN
        send(0, 16'h7FFF, 16'h0001, 1'b0);
        wait_idle();
        send(1, 16'hFFFF, 16'h0001, 1'b0);
        wait_idle();
`endif

        // Randomised traffic with random consumer backpressure
        s[0] = hs_count[0];
        s[1] = hs_count[1];
        for (int c = 0; c < 1500; c++) begin
            @(posedge Clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (rv[n]) begin
                    if (hs_count[n] != s[n]) begin
                        s[n]  = hs_count[n];
                        rv[n] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        rv[n] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    ra[n] = ($urandom_range(0, 4) == 0) ? 16'hFFFF : WIDTH'($urandom);
                    rb[n] = ($urandom_range(0, 4) == 0) ? 16'h8000 : WIDTH'($urandom);
                    rc[n] = 1'($urandom_range(0, 1));
                    rv[n] = 1'b1;
                end
            end
            res_rdy = ($urandom_range(0, 3) != 0);
        end
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        res_rdy = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
